// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage with in-order imem request channel, prefetch queue
// and IF/ID register; stale responses after a redirect are discarded via drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [31:0] ImemReqAddr,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pcf;
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [AW-1:0] head, tail, fill_idx;
    logic [CW-1:0] count, nf, drop;
    logic          hs, rsp_drop, rsp_fill, pop;

    // filled entries are always a contiguous run starting at head
    assign fill_idx     = head + nf[AW-1:0];
    assign ImemReqAddr  = pcf;
    assign ImemReqValid = !rst && !StallF && (count + drop < CW'(DEPTH));
    assign hs           = ImemReqValid && ImemReqReady;
    assign rsp_drop     = ImemRspValid && drop != '0;
    assign rsp_fill     = ImemRspValid && drop == '0 && nf != count;
    assign pop          = !PCSrcE && !FlushD && !StallD && nf != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcf   <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            nf    <= '0;
            drop  <= '0;
        end else if (PCSrcE) begin
            pcf   <= PCTargetE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            nf    <= '0;
            drop  <= drop + (count - nf) + CW'(hs) - CW'(rsp_drop || rsp_fill);
        end else begin
            pcf   <= hs ? pcf + 32'd4 : pcf;
            head  <= head + AW'(pop);
            tail  <= tail + AW'(hs);
            count <= count + CW'(hs) - CW'(pop);
            nf    <= nf + CW'(rsp_fill) - CW'(pop);
            drop  <= drop - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (hs)
            pc_q[tail] <= pcf;
        if (rsp_fill)
            instr_q[fill_idx] <= ImemRspData;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= pop ? instr_q[head] : NOP_INSTR;
            PCD      <= pop ? pc_q[head] : PCD;
            PCPlus4D <= pop ? pc_q[head] + 32'd4 : PCPlus4D;
            ValidD   <= pop;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order fixed-latency memory model.
module tb_fetch_unit;
    logic        clk, rst, StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReqValid, ImemReqReady, ImemRspValid;
    logic [31:0] ImemReqAddr, ImemRspData;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic [31:0] pq_addr [$];
    int          pq_due  [$];

    fetch_unit dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ImemReqValid(ImemReqValid), .ImemReqReady(ImemReqReady), .ImemReqAddr(ImemReqAddr),
        .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00A0_0093;
            32'h4:   return 32'h0010_0113;
            32'h8:   return 32'h0041_2283;
            default: return {a[23:0], 8'h13};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // one clock: present due response, note handshake, advance memory model
    task automatic step();
        logic        hs_now;
        logic [31:0] a;
        ImemRspValid = 1'b0;
        ImemRspData  = '0;
        if (pq_addr.size() > 0 && pq_due[0] <= cyc) begin
            ImemRspValid = 1'b1;
            ImemRspData  = mem(pq_addr[0]);
        end
        #1;
        hs_now = ImemReqValid & ImemReqReady;
        a      = ImemReqAddr;
        @(posedge clk);
        cyc++;
        if (ImemRspValid) begin
            void'(pq_addr.pop_front());
            void'(pq_due.pop_front());
        end
        if (hs_now) begin
            pq_addr.push_back(a);
            pq_due.push_back(cyc + lat - 1);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = '0; ImemReqReady = 1'b1; ImemRspValid = 1'b0; ImemRspData = '0;
        pq_addr.delete();
        pq_due.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic expect_d(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(ValidD), 32'd1);
        check({tag, "_pcd"}, PCD, pc);
        check({tag, "_instr"}, InstrD, mem(pc));
        check({tag, "_pc4"}, PCPlus4D, pc + 32'd4);
    endtask

    initial begin
        rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = '0; ImemReqReady = 1'b1; ImemRspValid = 1'b0; ImemRspData = '0;
        #1;
        check("rst_reqvalid", 32'(ImemReqValid), 32'd0);
        check("rst_instr", InstrD, 32'h0000_0013);
        check("rst_pcd", PCD, 32'h0);
        check("rst_valid", 32'(ValidD), 32'd0);

        // sequential fetch, 1-cycle memory
        lat = 1;
        do_reset();
        check("seq_reqvalid0", 32'(ImemReqValid), 32'd1);
        check("seq_addr0", ImemReqAddr, 32'h0);
        repeat (3) step();
        expect_d("seq_c3", 32'h0);
        step();
        expect_d("seq_c4", 32'h4);
        step();
        check("seq_c5_bubble", 32'(ValidD), 32'd0);
        step();
        expect_d("seq_c6", 32'h8);

        // load-use stall while the lw is in Decode
        StallF = 1'b1; StallD = 1'b1;
        #1 check("stall_noreq", 32'(ImemReqValid), 32'd0);
        step();
        StallF = 1'b0; StallD = 1'b0;
        expect_d("stall_hold", 32'h8);
        #1;
        check("stall_reqvalid", 32'(ImemReqValid), 32'd1);
        check("stall_addr", ImemReqAddr, 32'h10);
        step();
        expect_d("stall_next", 32'hC);

        // backpressure: ready low for 5 cycles
        lat = 1;
        do_reset();
        repeat (2) step();
        ImemReqReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 4) begin
                check("bp_reqvalid", 32'(ImemReqValid), 32'd1);
                check("bp_addr", ImemReqAddr, 32'h8);
            end
            if (i == 0) expect_d("bp_c3", 32'h0);
            if (i == 1) expect_d("bp_c4", 32'h4);
            if (i >= 2) check("bp_drained", 32'(ValidD), 32'd0);
        end
        ImemReqReady = 1'b1;
        repeat (3) step();
        expect_d("bp_resume", 32'h8);

        // redirect with two requests in flight, latency 3
        lat = 3;
        do_reset();
        repeat (2) step();
        PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h100;
        step();
        PCSrcE = 1'b0; FlushD = 1'b0;
        check("rd_flush_valid", 32'(ValidD), 32'd0);
        check("rd_flush_instr", InstrD, 32'h0000_0013);
        check("rd_dropfull", 32'(ImemReqValid), 32'd0);
        step();
        check("rd_req_target", 32'(ImemReqValid), 32'd1);
        check("rd_addr_target", ImemReqAddr, 32'h100);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rd_no_stale", 32'(ValidD), 32'd0);
        end
        step();
        expect_d("rd_first", 32'h100);
        step();
        expect_d("rd_second", 32'h104);

        // redirect coinciding with a handshake and a response, latency 1
        lat = 1;
        do_reset();
        repeat (4) step();
        PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h200;
        step();
        PCSrcE = 1'b0; FlushD = 1'b0;
        check("rh_valid5", 32'(ValidD), 32'd0);
        check("rh_req5", 32'(ImemReqValid), 32'd1);
        check("rh_addr5", ImemReqAddr, 32'h200);
        step();
        check("rh_valid6", 32'(ValidD), 32'd0);
        check("rh_req6", 32'(ImemReqValid), 32'd1);
        check("rh_addr6", ImemReqAddr, 32'h204);
        step();
        check("rh_full7", 32'(ImemReqValid), 32'd0);
        check("rh_valid7", 32'(ValidD), 32'd0);
        step();
        expect_d("rh_first", 32'h200);
        step();
        expect_d("rh_second", 32'h204);

        // async reset mid-fetch, late response after release
        lat = 2;
        do_reset();
        repeat (4) step();
        StallD = 1'b1;
        step();
        expect_d("ar_held", 32'h0);
        StallD = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_instr", InstrD, 32'h0000_0013);
        check("ar_pc4", PCPlus4D, 32'h0);
        check("ar_valid", 32'(ValidD), 32'd0);
        check("ar_req", 32'(ImemReqValid), 32'd0);
        step();
        rst = 1'b0; StallF = 1'b1;
        step();
        StallF = 1'b0;
        #1;
        check("ar_req_after", 32'(ImemReqValid), 32'd1);
        check("ar_addr_after", ImemReqAddr, 32'h0);
        repeat (2) step();
        check("ar_no_stale9", 32'(ValidD), 32'd0);
        step();
        check("ar_no_stale10", 32'(ValidD), 32'd0);
        step();
        expect_d("ar_first", 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
